bp_resolve: RTL
===============

# bp_resolve

Branch-resolution end of the branch-predictor loop. Sits at the execute stage: compares each resolved instruction's actual control flow against the prediction it carried from IF1, raises a one-cycle flush with the correct redirect PC on mispredict, and queues BTB update writes (index, taken bit, target) into a small FIFO drained into the IF1 BTB write port when that port is free.

## Interface
- `QDEPTH`, default 4: update-queue depth, power of two, minimum 2.
- `IDX_W`, default 6: BTB index width; the index is `pc[IDX_W+1:2]`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `res_valid` in 1: an instruction is resolved this cycle.
- `res_is_br` in 1: the resolved instruction is a branch or jump.
- `res_pc` in 32: PC of the resolved instruction.
- `res_taken` in 1: actual direction (0 when `res_is_br`=0).
- `res_target` in 32: actual taken target.
- `res_pred_taken` in 1: IF1 predicted taken.
- `res_pred_target` in 32: IF1 predicted target.
- `ex_stall` out 1: queue full; EX must hold its instruction.
- `flush` out 1: mispredict flush pulse.
- `redirect_pc` out 32: fetch restart PC, valid while `flush`=1.
- `btb_busy` in 1: BTB write port unavailable this cycle.
- `upd_we` out 1: BTB write strobe.
- `upd_idx` out IDX_W: BTB index.
- `upd_hitted` out 1: actual taken bit shifted into the BTB history.
- `upd_wtarget` out 32: target written to the BTB.
- `stat_br_cnt` out 32: resolved-branch counter.
- `stat_mis_cnt` out 32: mispredict counter.

## Operation
- Accept: `acc = res_valid & ~ex_stall & ~flush`. Resolutions in the cycle `flush`=1 are wrong-path and are dropped: no flush, no push, no count.
- Mispredict when accepted: `res_pred_taken != res_taken`, or both taken and `res_pred_target != res_target`. A non-branch with `res_pred_taken`=1 is a mispredict with `res_taken`=0.
- Redirect PC: `res_taken ? res_target : res_pc + 32'd4`, with 32-bit wrap (0xFFFFFFFC + 4 = 0).
- Push to the queue on `acc & (res_is_br | res_pred_taken)`. The entry is {`res_pc[IDX_W+1:2]`, `res_taken`, `res_taken ? res_target : 32'b0`}.
- Queue: circular FIFO with read/write pointers and an occupancy count of 0..QDEPTH. `ex_stall = (count == QDEPTH)`, taken from the registered count only.
- Drain: `upd_we = (count != 0) & ~btb_busy`. The `upd_idx`, `upd_hitted` and `upd_wtarget` outputs present the head entry whenever count is nonzero, and are 0 when the queue is empty. A pop occurs on `upd_we`.
- Simultaneous push and pop: the count is unchanged and both pointers advance. A push is never attempted while full, so overflow is impossible. A pop is never attempted while empty, so underflow is impossible.
- Reset (any cycle, including mid-drain or with `flush` pending): queue emptied, pointers, count and counters cleared.
- Reset values: `flush`=0, `redirect_pc`=0, `ex_stall`=0, `upd_we`=0, `upd_idx`=0, `upd_hitted`=0, `upd_wtarget`=0, both stat counters 0.

## Timing
- Accepted mispredict in cycle N: `flush`=1 and `redirect_pc` valid in cycle N+1 (registered) for exactly one cycle.
- Push at the end of cycle N. The entry is the head no earlier than N+1, so the earliest `upd_we` is N+1.
- `upd_we` depends combinationally on `btb_busy`. All other outputs are registered.
- Back-to-back flushes are impossible, because the cycle after a flush drops its input.
- `ex_stall` deasserts the cycle after a pop from a full queue.
- Queue drain throughput: one entry per cycle with `btb_busy`=0.

## Configuration
- `BP_STAT_EN` defined:
  - `stat_br_cnt` increments on each accepted resolution with `res_is_br`=1.
  - `stat_mis_cnt` increments on each accepted mispredict.
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- `BP_STAT_EN` undefined: no counter registers; both outputs are tied to 0.

## Test plan
- Correct prediction: pc=0x1C000010, taken, target=0x1C000100, predicted taken with the same target → no flush; next cycle `upd_we`=1, `upd_idx`=4, `upd_hitted`=1, `upd_wtarget`=0x1C000100.
- Direction mispredict: pc=0x1C000020, not taken, predicted taken → N+1 `flush`=1, `redirect_pc`=0x1C000024, `upd_hitted`=0. A `res_valid` in N+1 is ignored (no second push).
- Target mispredict: both taken, predicted target 0x1C000200, actual 0x1C000300 → `flush`, `redirect_pc`=0x1C000300, `upd_wtarget`=0x1C000300, `stat_mis_cnt`=1 with `BP_STAT_EN`.
- Backpressure: `btb_busy`=1 and 5 correct branches in consecutive cycles → `ex_stall`=1 after 4 pushes and the 5th is not accepted. Drop `btb_busy` → 4 `upd_we` pulses in FIFO order; after the first pop `ex_stall`=0 and the 5th is accepted.
- Non-branch false hit: `res_is_br`=0, `res_pred_taken`=1, pc=0x1C0000FC → `flush`, `redirect_pc`=0x1C000100, update with `upd_hitted`=0 and `upd_idx`=63. `stat_br_cnt` is unchanged.
- Reset mid-drain: 3 entries queued, `rst_n`=0 for one cycle → next cycle `upd_we`=0, `ex_stall`=0, `flush`=0, counters 0. A subsequent single push drains correctly.

Source files
------------

// File: rtl/bp_resolve.sv
// bp_resolve -- branch resolution at execute.
//
// Compares each resolved instruction against the prediction it carried from
// IF1. On a mispredict it raises a registered one-cycle flush together with
// the correct fetch restart PC. Branches, and non-branches that IF1 wrongly
// predicted taken, queue a BTB update (index, taken bit, target) into a small
// circular FIFO. The FIFO drains into the IF1 BTB write port whenever
// btb_busy is low.
//
// Optional feature: define BP_STAT_EN to build the resolved-branch and
// mispredict counters. When it is undefined, both stat outputs are tied to 0.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   res_*             resolution from EX: valid, is_br, pc, taken, target,
//                     pred_taken, pred_target
//   ex_stall          queue full; EX holds its instruction
//   flush             one-cycle mispredict pulse
//   redirect_pc       restart PC, valid while flush=1
//   btb_busy          BTB write port unavailable this cycle
//   upd_we            BTB write strobe (combinational on btb_busy)
//   upd_idx           head-entry BTB index (0 when the queue is empty)
//   upd_hitted        head-entry taken bit (0 when the queue is empty)
//   upd_wtarget       head-entry target (0 when the queue is empty)
//   stat_br_cnt       accepted branch count
//   stat_mis_cnt      accepted mispredict count
module bp_resolve #(
  parameter int QDEPTH = 4,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  input  logic             res_is_br,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_pred_target,
  output logic             ex_stall,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  input  logic             btb_busy,
  output logic             upd_we,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_hitted,
  output logic [31:0]      upd_wtarget,
  output logic [31:0]      stat_br_cnt,
  output logic [31:0]      stat_mis_cnt
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic [31:0]      tgt;
  } upd_t;

  upd_t          q_mem [QDEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic  acc, mis, mis_acc, push, pop, q_nonempty;
  logic  [31:0] redir;
  upd_t  ent, head;

  // Nothing is accepted in the flush cycle: that instruction is on the wrong path.
  assign acc      = res_valid & ~ex_stall & ~flush;
  assign mis      = (res_pred_taken != res_taken) |
                    (res_taken & res_pred_taken & (res_pred_target != res_target));
  assign mis_acc  = acc & mis;
  assign redir    = res_taken ? res_target : res_pc + 32'd4;

  // A non-branch that IF1 predicted taken must also write the BTB, so that
  // the false hit is retrained.
  assign push     = acc & (res_is_br | res_pred_taken);
  assign ent.idx  = res_pc[IDX_W+1:2];
  assign ent.hit  = res_taken;
  assign ent.tgt  = res_taken ? res_target : 32'b0;

  assign q_nonempty = (count != '0);
  assign ex_stall   = (count == CW'(QDEPTH));
  assign upd_we     = q_nonempty & ~btb_busy;
  assign pop        = upd_we;

  assign head        = q_nonempty ? q_mem[rptr] : '0;
  assign upd_idx     = head.idx;
  assign upd_hitted  = head.hit;
  assign upd_wtarget = head.tgt;

  // Entry storage needs no reset: reads are gated by a nonzero count.
  always_ff @(posedge clk) begin
    if (push) q_mem[wptr] <= ent;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
    end else begin
      flush <= mis_acc;
      if (mis_acc) redirect_pc <= redir;
      if (push)    wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef BP_STAT_EN
  logic [31:0] br_q, mis_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (acc & res_is_br) br_q  <= br_q + 32'd1;
      if (mis_acc)         mis_q <= mis_q + 32'd1;
    end
  end

  assign stat_br_cnt  = br_q;
  assign stat_mis_cnt = mis_q;
`else
  assign stat_br_cnt  = '0;
  assign stat_mis_cnt = '0;
`endif

endmodule
